// File: rtl/ram_loader_pkg.sv
// -----------------------------------------------------------------------------
// ram_loader_pkg
// Shared definitions for the program-image loader: default RAM geometry,
// loader state encoding and small decode helpers used by the loader top.
// -----------------------------------------------------------------------------
package ram_loader_pkg;

  // Default RAM geometry: 8K words of 16 bits.
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 16;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // True while the loader owns the RAM port and accepts stream words.
  function automatic logic isLoadState(input state_t st);
    return (st == ST_LOAD);
  endfunction

  // True while the CPU owns the RAM port.
  function automatic logic isRunState(input state_t st);
    return (st == ST_RUN);
  endfunction

endpackage

// File: rtl/ram_loader_ram_port_mux.sv
// -----------------------------------------------------------------------------
// ram_port_mux
// Combinational selector for the single RAM port. When runSel is high the CPU
// drives the RAM directly; otherwise the loader-side request is forwarded.
// Ports:
//   runSel                       - 1: CPU side owns the port
//   cpuAddr/cpuData/cpuWe        - CPU-side request
//   loadAddr/loadData/loadWe     - loader-side request
//   ramAddr/ramData/ramWe        - selected request toward the RAM
// -----------------------------------------------------------------------------
module ram_port_mux #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              runSel,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuData,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [DATA_W-1:0] loadData,
  input  logic              loadWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramData,
  output logic              ramWe
);

  assign ramAddr = runSel ? cpuAddr : loadAddr;
  assign ramData = runSel ? cpuData : loadData;
  assign ramWe   = runSel ? cpuWe   : loadWe;

endmodule

// File: rtl/ram_loader.sv
// -----------------------------------------------------------------------------
// ram_loader
// Streams a program image into a single-port RAM while holding the CPU in
// reset, then releases the CPU and hands it the RAM port. A reload request in
// RUN or ERR restarts loading from address 0.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_last- load stream (ready only while loading)
//   reload                       - single-cycle reload request (RUN/ERR only)
//   cpu_addr/cpu_data/cpu_wrEn   - CPU RAM request, forwarded in RUN
//   cpu_rst                      - registered reset into the CPU
//   ram_addr/ram_data/ram_we     - the single RAM port
//   done                         - image loaded, CPU running
//   err                          - image longer than the RAM
//   word_count                   - words accepted in the current load
// -----------------------------------------------------------------------------
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              reload,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_wrEn,
  output logic              cpu_rst,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  // Last RAM address; an accepted non-final word here means overflow.
  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
  // word_count saturates at the RAM depth.
  localparam logic [ADDR_W:0]   WC_MAX  = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_r;
  logic [ADDR_W-1:0]   loadPtr_r;
  logic [ADDR_W:0]     wordCount_r;
  logic                cpuRst_r;
  logic                done_r;
  logic                err_r;

  logic                loadSel_s;
  logic                runSel_s;
  logic                accept_s;
  logic [ADDR_W:0]     wcNext_s;
  logic [ADDR_W-1:0]   loadAddr_s;
  logic [DATA_W-1:0]   loadData_s;

  // Ready is a pure state decode so a word can be written in the cycle it is offered.
  assign loadSel_s = isLoadState(state_r);
  assign runSel_s  = isRunState(state_r);
  assign accept_s  = s_valid && loadSel_s;
  assign wcNext_s  = (wordCount_r == WC_MAX) ? WC_MAX
                                             : (wordCount_r + {{ADDR_W{1'b0}}, 1'b1});

  // Outside LOAD the loader side still presents the CPU address but never writes,
  // so CPU writes are discarded in IDLE, FLUSH and ERR.
  assign loadAddr_s = loadSel_s ? loadPtr_r : cpu_addr;
  assign loadData_s = loadSel_s ? s_data    : cpu_data;

  // Sequencer: state, load pointer, word counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      loadPtr_r   <= {ADDR_W{1'b0}};
      wordCount_r <= {(ADDR_W+1){1'b0}};
      cpuRst_r    <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r     <= ST_LOAD;
          loadPtr_r   <= {ADDR_W{1'b0}};
          wordCount_r <= {(ADDR_W+1){1'b0}};
          cpuRst_r    <= 1'b1;
          done_r      <= 1'b0;
          err_r       <= 1'b0;
        end
        ST_LOAD: begin
          cpuRst_r <= 1'b1;
          done_r   <= 1'b0;
          if (accept_s) begin
            wordCount_r <= wcNext_s;
            if (s_last) begin
              state_r <= ST_FLUSH;
            end else if (loadPtr_r == PTR_MAX) begin
              // Pointer is held at the top; it must never wrap onto address 0.
              state_r <= ST_ERR;
              err_r   <= 1'b1;
            end else begin
              loadPtr_r <= loadPtr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_FLUSH: begin
          // cpu_rst drops together with the move to RUN.
          state_r  <= ST_RUN;
          cpuRst_r <= 1'b0;
          done_r   <= 1'b1;
        end
        ST_RUN: begin
          if (reload) begin
            // CPU goes back into reset on the same edge LOAD is entered.
            state_r     <= ST_LOAD;
            loadPtr_r   <= {ADDR_W{1'b0}};
            wordCount_r <= {(ADDR_W+1){1'b0}};
            cpuRst_r    <= 1'b1;
            done_r      <= 1'b0;
          end
        end
        ST_ERR: begin
          if (reload) begin
            state_r     <= ST_LOAD;
            loadPtr_r   <= {ADDR_W{1'b0}};
            wordCount_r <= {(ADDR_W+1){1'b0}};
            err_r       <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          loadPtr_r   <= {ADDR_W{1'b0}};
          wordCount_r <= {(ADDR_W+1){1'b0}};
          cpuRst_r    <= 1'b1;
          done_r      <= 1'b0;
          err_r       <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready    = loadSel_s;
  assign cpu_rst    = cpuRst_r;
  assign done       = done_r;
  assign err        = err_r;
  assign word_count = wordCount_r;

  ram_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ramPortMux (
    .runSel   (runSel_s),
    .cpuAddr  (cpu_addr),
    .cpuData  (cpu_data),
    .cpuWe    (cpu_wrEn),
    .loadAddr (loadAddr_s),
    .loadData (loadData_s),
    .loadWe   (accept_s),
    .ramAddr  (ram_addr),
    .ramData  (ram_data),
    .ramWe    (ram_we)
  );

endmodule

// File: tb/tb_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_ram_loader
// Directed sequence with random data against a behavioural RAM image model.
// -----------------------------------------------------------------------------
module tb_ram_loader;

  localparam int AW    = 13;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          reload;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          cpu_wrEn;
  logic          cpu_rst;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic          done;
  logic          err;
  logic [AW:0]   word_count;

  // RAM driven by the DUT port, and the expected image contents.
  logic [DW-1:0] ram    [DEPTH];
  logic [DW-1:0] expRam [DEPTH];
  int            expPtr;
  int            expCount;

  int nCheck = 0;
  int nPass  = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we === 1'b1) ram[ram_addr] <= ram_data;
  end

  ram_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .reload     (reload),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_wrEn   (cpu_wrEn),
    .cpu_rst    (cpu_rst),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCheck++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer one word, wait (bounded) for acceptance, update the image model.
  task automatic sendWord(input logic [DW-1:0] d, input logic last);
    int waited;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    #1;
    while (s_ready !== 1'b1 && waited < 20) begin
      @(posedge clk);
      #3;
      waited++;
    end
    chk("accept_ready", 32'(s_ready), 32'd1);
    chk("accept_we",    32'(ram_we),  32'd1);
    chk("accept_addr",  32'(ram_addr), 32'(expPtr));
    expRam[expPtr] = d;
    if (expPtr < DEPTH - 1) expPtr++;
    if (expCount < DEPTH) expCount++;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic chkImage(input string tag, input int n);
    for (int i = 0; i < n; i++) chk(tag, 32'(ram[i]), 32'(expRam[i]));
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    rst = 1'b1; s_valid = 1'b1; s_data = 16'h5A5A; s_last = 1'b0; reload = 1'b0;
    cpu_addr = 13'd0; cpu_data = 16'h0000; cpu_wrEn = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    // Reset state, with stream and CPU requests active.
    chk("rst_cpu_rst",    32'(cpu_rst),    32'd1);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_err",        32'(err),        32'd0);
    chk("rst_s_ready",    32'(s_ready),    32'd0);
    chk("rst_ram_we",     32'(ram_we),     32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    s_valid = 1'b0; cpu_wrEn = 1'b0;
    rst = 1'b0;
    #1;
    chk("idle_s_ready", 32'(s_ready), 32'd0);
    tick();
    #1;
    chk("load_s_ready",    32'(s_ready),    32'd1);
    chk("load_word_count", 32'(word_count), 32'd0);

    // Three-word image, back to back.
    expPtr = 0; expCount = 0;
    sendWord(16'h1111, 1'b0);
    sendWord(16'h2222, 1'b0);
    sendWord(16'h3333, 1'b1);
    cpu_wrEn = 1'b1; cpu_addr = 13'd73; cpu_data = 16'h0BAD;
    #1;
    chk("flush_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("flush_done",    32'(done),    32'd0);
    chk("flush_s_ready", 32'(s_ready), 32'd0);
    chk("flush_ram_we",  32'(ram_we),  32'd0);
    cpu_wrEn = 1'b0;
    tick();
    #1;
    chk("run_cpu_rst",    32'(cpu_rst),    32'd0);
    chk("run_done",       32'(done),       32'd1);
    chk("run_word_count", 32'(word_count), 32'(expCount));
    chkImage("img3", 3);

    // CPU write in RUN goes straight through.
    cpu_wrEn = 1'b1; cpu_addr = 13'd72; cpu_data = 16'd255;
    #1;
    chk("run_we",   32'(ram_we),   32'd1);
    chk("run_addr", 32'(ram_addr), 32'd72);
    tick();
    expRam[72] = 16'd255;
    for (int i = 0; i < 4; i++) begin
      a = 13'($urandom_range(100, DEPTH - 1));
      d = 16'($urandom);
      cpu_addr = a; cpu_data = d;
      tick();
      expRam[a] = d;
      chk("run_rand_wr", 32'(ram[a]), 32'(d));
    end
    cpu_wrEn = 1'b0;
    chk("run_ram72", 32'(ram[72]), 32'(expRam[72]));

    // Reload from RUN, then a gappy four-word image with CPU writes attempted.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    #1;
    chk("reload_cpu_rst", 32'(cpu_rst),    32'd1);
    chk("reload_done",    32'(done),       32'd0);
    chk("reload_wc",      32'(word_count), 32'd0);
    chk("reload_ready",   32'(s_ready),    32'd1);
    expPtr = 0; expCount = 0;
    for (int i = 0; i < 4; i++) begin
      sendWord(16'($urandom), (i == 3));
      if (i < 3) begin
        s_data = 16'($urandom);
        cpu_wrEn = 1'b1; cpu_addr = 13'd72; cpu_data = 16'h00AA;
        #1;
        chk("gap_no_we", 32'(ram_we), 32'd0);
        tick();
        cpu_wrEn = 1'b0;
      end
    end
    tick();
    #1;
    chk("gap_done", 32'(done),       32'd1);
    chk("gap_wc",   32'(word_count), 32'(expCount));
    chkImage("img4", 5);
    chk("load_ram72", 32'(ram[72]), 32'(expRam[72]));

    // Overflow: a full RAM of words with no last flag.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    #1;
    chk("ovf_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1; s_last = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      s_data = 16'($urandom);
      expRam[i] = s_data;
      @(posedge clk);
      #2;
    end
    // Keep offering words; none may land anywhere.
    for (int i = 0; i < 3; i++) begin
      s_data = 16'($urandom);
      cpu_wrEn = 1'b1; cpu_addr = 13'd0; cpu_data = 16'hDEAD;
      #1;
      chk("err_no_we", 32'(ram_we), 32'd0);
      tick();
    end
    s_valid = 1'b0; cpu_wrEn = 1'b0;
    expCount = DEPTH;
    chk("err_flag",    32'(err),        32'd1);
    chk("err_ready",   32'(s_ready),    32'd0);
    chk("err_cpu_rst", 32'(cpu_rst),    32'd1);
    chk("err_done",    32'(done),       32'd0);
    chk("err_wc",      32'(word_count), 32'(expCount));
    chk("err_ram0",    32'(ram[0]),         32'(expRam[0]));
    chk("err_ramtop",  32'(ram[DEPTH - 1]), 32'(expRam[DEPTH - 1]));
    reload = 1'b1;
    tick();
    reload = 1'b0;
    #1;
    chk("err_reload_err",   32'(err),        32'd0);
    chk("err_reload_wc",    32'(word_count), 32'd0);
    chk("err_reload_ready", 32'(s_ready),    32'd1);

    // Reset in the middle of a five-word load.
    expPtr = 0; expCount = 0;
    sendWord(16'($urandom), 1'b0);
    sendWord(16'($urandom), 1'b0);
    s_valid = 1'b1; s_data = 16'($urandom); s_last = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_we",      32'(ram_we),     32'd0);
    chk("mid_rst_ready",   32'(s_ready),    32'd0);
    chk("mid_rst_wc",      32'(word_count), 32'd0);
    chk("mid_rst_cpu_rst", 32'(cpu_rst),    32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    chk("mid_ram2", 32'(ram[2]), 32'(expRam[2]));
    tick();
    #1;
    chk("mid_rel_wc",    32'(word_count), 32'd0);
    chk("mid_rel_load",  32'(s_ready),    32'd1);

    // Single-word image.
    expPtr = 0; expCount = 0;
    sendWord(16'($urandom), 1'b1);
    tick();
    #1;
    chk("one_done",    32'(done),       32'd1);
    chk("one_cpu_rst", 32'(cpu_rst),    32'd0);
    chk("one_wc",      32'(word_count), 32'(expCount));
    chkImage("img1", 2);

    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, RAM data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_valid  input  1  load-stream word valid.
REQ-006 SHALL have port s_ready  output  1  load-stream word accepted when s_valid && s_ready.
REQ-007 SHALL have port s_data  input  DATA_W  program word to write.
REQ-008 SHALL have port s_last  input  1  marks final word of program image.
REQ-009 SHALL have port reload  input  1  single-cycle request to reload image.
REQ-010 SHALL have port cpu_addr  input  ADDR_W  CPU address toward RAM.
REQ-011 SHALL have port cpu_data  input  DATA_W  CPU write data toward RAM.
REQ-012 SHALL have port cpu_wrEn  input  1  CPU write enable.
REQ-013 SHALL have port cpu_rst  output  1  reset driven into the CPU.
REQ-014 SHALL have ports ram_addr  output  ADDR_W, ram_data  output  DATA_W, ram_we  output  1: the single RAM port.
REQ-015 SHALL have port done  output  1  image loaded, CPU running.
REQ-016 SHALL have port err  output  1  image overflowed RAM.
REQ-017 SHALL have port word_count  output  ADDR_W+1  words accepted in current load.

Function
REQ-018 SHALL implement states IDLE, LOAD, FLUSH, RUN, ERR.
REQ-019 SHALL transition: IDLE->LOAD unconditionally after one cycle; LOAD->FLUSH on accepted word with s_last=1; LOAD->ERR on accepted word at pointer 2^ADDR_W-1 with s_last=0; FLUSH->RUN unconditionally; RUN->LOAD on reload; ERR->LOAD on reload.
REQ-020 SHALL ignore reload in IDLE, LOAD, FLUSH.
REQ-021 SHALL drive s_ready=1 only in LOAD, combinationally decoded from state.
REQ-022 SHALL, in LOAD, drive ram_addr=load pointer, ram_data=s_data, ram_we=s_valid&&s_ready in the same cycle (zero latency).
REQ-023 SHALL increment pointer and word_count by 1 per accepted word; no skipping on s_valid gaps.
REQ-024 SHALL, in RUN, pass cpu_addr, cpu_data, cpu_wrEn straight to ram_addr, ram_data, ram_we.
REQ-025 SHALL, in IDLE, FLUSH, ERR, hold ram_we=0 and discard cpu_wrEn; ram_addr=cpu_addr.
REQ-026 SHALL register cpu_rst: 1 in all states except RUN; falls on the first RUN cycle (two cycles after last word accepted).
REQ-027 SHALL register done=1 exactly while in RUN; err=1 exactly while in ERR.
REQ-028 SHALL, on entry to LOAD, clear pointer and word_count to 0 and assert cpu_rst the same cycle LOAD is entered from RUN.
REQ-029 SHALL saturate word_count at 2^ADDR_W; pointer SHALL NOT wrap into address 0.
REQ-030 SHALL treat a single word with s_last=1 as a valid image (word_count=1).

Reset
REQ-031 SHALL, while rst=1, force state IDLE, pointer 0, word_count 0, cpu_rst 1, done 0, err 0, s_ready 0, ram_we 0.
REQ-032 SHALL, on rst asserted mid-load or mid-run, abandon the operation immediately with no further RAM write.

Structure
REQ-033 SHALL place ADDR_W/DATA_W defaults and the state encoding in shared package ram_loader_pkg.
REQ-034 SHALL isolate the RAM-port selection in sub-module ram_port_mux (combinational, select = state==RUN).

Verification
REQ-035 SHALL cover: reset release, stream 3 words 16'h1111,16'h2222,16'h3333 (last on third) -> RAM[0..2] hold them, word_count=3, cpu_rst falls 2 cycles after third accept, done=1.
REQ-036 SHALL cover: s_valid toggling every other cycle for 4 words -> RAM[0..3] contiguous, no duplicates.
REQ-037 SHALL cover: in RUN, cpu_wrEn=1, cpu_addr=72, cpu_data=255 -> RAM[72]=255; same write during LOAD -> RAM[72] unchanged.
REQ-038 SHALL cover: 8192 words without s_last -> err=1, s_ready=0, cpu_rst=1, RAM[0] unchanged from first word; reload -> LOAD, err=0, word_count=0.
REQ-039 SHALL cover: reload pulse in RUN -> cpu_rst=1 next cycle, done=0, new image overwrites from address 0.
REQ-040 SHALL cover: rst asserted after 2 of 5 words -> ram_we=0 immediately, state IDLE, word_count=0 after release.
